// File: rtl/rr_decode_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin decode arbiter.
package rr_decode_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_decode_arbiter_decoder.sv
// Dataflow 3-to-8 decoder; the output is all zero whenever the enable is low.
module decoder_3to8_df
  import rr_decode_arbiter_pkg::*;
(
  output logic [N_REQ-1:0] out_o,
  input  logic [IDX_W-1:0] in_i,
  input  logic             en_i
);

  assign out_o = en_i ? (N_REQ'(1'b1) << in_i) : {N_REQ{1'b0}};

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter owning a shared 3-to-8 decoder: grant, hold until release,
// one-cycle break-before-make gap, then re-arbitrate from the slot after the last grantee.
module rr_decode_arbiter
  import rr_decode_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_en_o,
  output logic [N_REQ-1:0] grant_o,
  output logic             busy_o,
  output logic             timeout_evt_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               en_q, en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tevt_q, tevt_d;
  logic [IDX_W:0]     pick_s;
  logic               rel_done_s, rel_drop_s, rel_to_s;

  // Scan ptr, ptr+1, ... (mod N_REQ); MSB of the result flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand;
    res = {(IDX_W+1){1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    en_d       = 1'b0;
    cnt_d      = cnt_q;
    tevt_d     = 1'b0;
    pick_s     = rr_pick(req_i, ptr_q);
    rel_done_s = done_i;
    rel_drop_s = ~req_i[idx_q];
    rel_to_s   = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    case (state_q)
      IDLE: begin
        if (pick_s[IDX_W]) begin
          idx_d   = pick_s[IDX_W-1:0];
          en_d    = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (rel_done_s || rel_drop_s || rel_to_s) begin
          ptr_d   = idx_q + IDX_W'(1);
          state_d = GAP;
          tevt_d  = rel_to_s & ~rel_done_s & ~rel_drop_s;
        end else begin
          en_d  = 1'b1;
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= {IDX_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      en_q    <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      tevt_q  <= tevt_d;
    end
  end

  decoder_3to8_df u_dec (
    .out_o (grant_o),
    .in_i  (idx_q),
    .en_i  (en_q)
  );

  assign grant_idx_o   = idx_q;
  assign grant_en_o    = en_q;
  assign busy_o        = en_q;
  assign timeout_evt_o = tevt_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter with hand-computed expectations.
module tb_rr_decode_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_en;
  logic [7:0] grant;
  logic       busy;
  logic       timeout_evt;

  int n_checks = 0;
  int n_fail   = 0;

  rr_decode_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .done_i        (done),
    .grant_idx_o   (grant_idx),
    .grant_en_o    (grant_en),
    .grant_o       (grant),
    .busy_o        (busy),
    .timeout_evt_o (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    check_val({tag, "_en"},   32'(grant_en), 32'd1);
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_idx"},  32'(grant_idx), 32'(idx));
    check_val({tag, "_vec"},  32'(grant), 32'(oh));
  endtask

  task automatic expect_off(input string tag);
    check_val({tag, "_en"},   32'(grant_en), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_vec"},  32'(grant), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    tick();
    tick();
    expect_off("reset");
    check_val("reset_idx",  32'(grant_idx), 32'd0);
    check_val("reset_tevt", 32'(timeout_evt), 32'd0);
    rst_n = 1'b1;
    tick();
    expect_grant("first", 0);

    // Rotation over all eight requesters, wrapping back to 0.
    for (int g = 0; g < 9; g++) begin
      expect_grant($sformatf("rot%0d", g), g % 8);
      done = 1'b1;
      tick();
      done = 1'b0;
      expect_off($sformatf("rot%0d_gap", g));
      check_val($sformatf("rot%0d_tevt", g), 32'(timeout_evt), 32'd0);
      tick();
      expect_off($sformatf("rot%0d_idle", g));
      if (g == 8) req = 8'h00;
      tick();
    end
    expect_off("quiet");
    check_val("quiet_ptr", 32'(dut.ptr_q), 32'd1);

    // Single requester 5, released by done on its third grant cycle.
    req = 8'h20;
    tick();
    expect_grant("single_c0", 5);
    tick();
    expect_grant("single_c1", 5);
    tick();
    expect_grant("single_c2", 5);
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_off("single_gap");
    check_val("single_ptr", 32'(dut.ptr_q), 32'd6);
    tick();
    expect_off("single_idle");
    tick();
    expect_grant("single_regrant", 5);
    check_val("single_regrant_ptr", 32'(dut.ptr_q), 32'd6);

    // Requester drops its line mid-grant.
    req = 8'h00;
    tick();
    expect_off("drop_gap");
    check_val("drop_tevt", 32'(timeout_evt), 32'd0);
    check_val("drop_idx_hold", 32'(grant_idx), 32'd5);
    tick();
    tick();

    // Wrap and skip with requesters 0 and 7, ptr starting at 6.
    req = 8'h81;
    tick();
    expect_grant("wrap_a", 7);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("wrap_ptr0", 32'(dut.ptr_q), 32'd0);
    tick();
    tick();
    expect_grant("wrap_b", 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("wrap_ptr1", 32'(dut.ptr_q), 32'd1);
    tick();
    tick();
    expect_grant("wrap_c", 7);
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 8'h00;
    tick();
    tick();

    // Timeout: grant held exactly 16 cycles with no done.
    req = 8'h04;
    tick();
    for (int k = 0; k < 16; k++) begin
      expect_grant($sformatf("to_hold%0d", k), 2);
      check_val($sformatf("to_hold%0d_tevt", k), 32'(timeout_evt), 32'd0);
      tick();
    end
    expect_off("to_gap");
    check_val("to_pulse", 32'(timeout_evt), 32'd1);
    tick();
    expect_off("to_idle");
    check_val("to_pulse_end", 32'(timeout_evt), 32'd0);
    tick();
    expect_grant("to_regrant", 2);

    // done and requester drop together: single release, no timeout pulse.
    done = 1'b1;
    req  = 8'h00;
    tick();
    done = 1'b0;
    expect_off("both_gap");
    check_val("both_tevt", 32'(timeout_evt), 32'd0);
    check_val("both_ptr", 32'(dut.ptr_q), 32'd3);

    // Asynchronous reset in the middle of a grant.
    req = 8'h10;
    tick();
    expect_off("rst_pre_idle");
    tick();
    expect_grant("rst_pre", 4);
    #2;
    rst_n = 1'b0;
    #1;
    expect_off("rst_async");
    check_val("rst_async_ptr", 32'(dut.ptr_q), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    expect_grant("rst_post", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
